// File: rtl/imem_program_loader_pkg.sv
// Shared types and sizing for the instruction-memory program loader.
// Holds the FSM state encoding and the default word/address geometry.
// Header count is always 12 bits: low nibble of LEN_HI concatenated with LEN_LO.
package imem_program_loader_pkg;

    localparam int ADDR_W_DEF     = 12;
    localparam int INSTR_W_DEF    = 19;
    localparam int BYTES_PER_WORD = 3;
    localparam int CNT_W          = 12;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_LO = 4'd1,
        ST_LEN_HI = 4'd2,
        ST_B0     = 4'd3,
        ST_B1     = 4'd4,
        ST_B2     = 4'd5,
        ST_WRITE  = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERR    = 4'd8
    } state_e;

endpackage

// File: rtl/imem_program_loader_if.sv
// Host byte stream, instruction-memory write port and CPU control bundle.
// slave = loader side, master = host/CPU side.
// rx_valid/rx_ready form a plain valid-ready byte handshake.
interface imem_program_loader_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19
);
    logic               start;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               rx_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_hold;
    logic               cpu_pc_reset;
    logic               busy;
    logic               done;
    logic               error;

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, imem_we, imem_waddr, imem_wdata,
               cpu_hold, cpu_pc_reset, busy, done, error
    );

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_waddr, imem_wdata,
               cpu_hold, cpu_pc_reset, busy, done, error
    );
endinterface

// File: rtl/imem_program_loader_word_assembler.sv
// Collects three host bytes (low first) into one instruction word.
// Latency: word_o valid the cycle after the third byte is accepted; holds until the next word.
// No backpressure of its own; pad_bad_o flags a third byte with nonzero bits above the word.
module imem_program_loader_word_assembler
    import imem_program_loader_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               shift_en_i,
    input  logic [1:0]         byte_idx_i,
    input  logic [7:0]         byte_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               pad_bad_o
);
    localparam int HI_W = INSTR_W - 16;

    logic [7:0]         lo_q;
    logic [7:0]         mid_q;
    logic [INSTR_W-1:0] word_q;

    // Bits of the top byte that do not fit the word must be zero.
    assign pad_bad_o = (byte_i >> HI_W) != 8'd0;
    assign word_o    = word_q;

    // Shift bytes in by position; a bad top byte leaves the previous word untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lo_q   <= '0;
            mid_q  <= '0;
            word_q <= '0;
        end else if (shift_en_i) begin
            case (byte_idx_i)
                2'd0:    lo_q  <= byte_i;
                2'd1:    mid_q <= byte_i;
                default: if (!pad_bad_o) word_q <= {byte_i[HI_W-1:0], mid_q, lo_q};
            endcase
        end
    end
endmodule

// File: rtl/imem_program_loader.sv
// Loads the instruction memory from a length-prefixed host byte stream, stalling the CPU meanwhile.
// Latency: one WRITE cycle after each word's third byte; DONE one cycle after the last write.
// Backpressure: rx_ready drops during WRITE/DONE/ERR/IDLE; rx_valid gaps simply stall the FSM.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int BASE_ADDR = 0
) (
    input  logic clock,
    input  logic reset,
    imem_program_loader_if.slave bus
);
    state_e             state_q, state_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               rx_ready_q;
    logic               imem_we_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic               cpu_hold_q;
    logic               pc_reset_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    logic               acc;
    logic               asm_en;
    logic [1:0]         byte_idx;
    logic [INSTR_W-1:0] word;
    logic               pad_bad;

    assign acc      = bus.rx_valid & rx_ready_q;
    assign asm_en   = acc & (state_q inside {ST_B0, ST_B1, ST_B2});
    assign byte_idx = (state_q == ST_B0) ? 2'd0 : (state_q == ST_B1) ? 2'd1 : 2'd2;

    imem_program_loader_word_assembler #(.INSTR_W(INSTR_W)) u_asm (
        .clock      (clock),
        .reset      (reset),
        .shift_en_i (asm_en),
        .byte_idx_i (byte_idx),
        .byte_i     (bus.rx_data),
        .word_o     (word),
        .pad_bad_o  (pad_bad)
    );

    // Next-state, header capture and address/count bookkeeping.
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        count_d  = count_q;
        addr_d   = addr_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (bus.start) state_d = ST_LEN_LO;
            ST_LEN_LO: if (acc) begin
                len_lo_d = bus.rx_data;
                state_d  = ST_LEN_HI;
            end
            ST_LEN_HI: if (acc) begin
                if (bus.rx_data[7:4] != 4'd0) begin
                    state_d = ST_ERR;
                end else begin
                    count_d = {bus.rx_data[3:0], len_lo_q};
                    if (count_d == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = ADDR_W'(BASE_ADDR);
                        state_d = ST_B0;
                    end
                end
            end
            ST_B0: if (acc) state_d = ST_B1;
            ST_B1: if (acc) state_d = ST_B2;
            ST_B2: if (acc) state_d = pad_bad ? ST_ERR : ST_WRITE;
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q - CNT_W'(1);
                state_d = (count_d == '0) ? ST_DONE : ST_B0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs, all decoded from the state being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_lo_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            rx_ready_q <= 1'b0;
            imem_we_q  <= 1'b0;
            waddr_q    <= '0;
            cpu_hold_q <= 1'b0;
            pc_reset_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            rx_ready_q <= state_d inside {ST_LEN_LO, ST_LEN_HI, ST_B0, ST_B1, ST_B2};
            imem_we_q  <= (state_d == ST_WRITE);
            busy_q     <= state_d inside {ST_LEN_LO, ST_LEN_HI, ST_B0, ST_B1, ST_B2, ST_WRITE};
            cpu_hold_q <= state_d inside {ST_LEN_LO, ST_LEN_HI, ST_B0, ST_B1, ST_B2, ST_WRITE, ST_ERR};
            done_q     <= (state_d == ST_DONE);
            error_q    <= (state_d == ST_ERR);
            pc_reset_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
            if (state_d == ST_WRITE) waddr_q <= addr_q;
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.imem_we      = imem_we_q;
    assign bus.imem_waddr   = waddr_q;
    assign bus.imem_wdata   = word;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.cpu_pc_reset = pc_reset_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: two instances (base 0 and base 4094) fed the same byte stream.
// Expected writes come from a word list turned into (base+i) mod 4096 address/data pairs.
// Host side inserts random idle gaps between bytes.
module tb_imem_program_loader;
    import imem_program_loader_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;

    int n_vec = 0;
    int n_err = 0;

    int          wa0[$], wd0[$], wa1[$], wd1[$];
    int          pulses0 = 0, pulses1 = 0;
    logic [18:0] mem0 [0:4095];
    logic [18:0] mem1 [0:4095];
    int          exp_w[$];

    always #5 clock = ~clock;

    imem_program_loader_if b0 ();
    imem_program_loader_if b1 ();

    assign b0.start    = start;
    assign b0.rx_valid = rx_valid;
    assign b0.rx_data  = rx_data;
    assign b1.start    = start;
    assign b1.rx_valid = rx_valid;
    assign b1.rx_data  = rx_data;

    imem_program_loader #(.BASE_ADDR(0))    dut0 (.clock(clock), .reset(reset), .bus(b0));
    imem_program_loader #(.BASE_ADDR(4094)) dut1 (.clock(clock), .reset(reset), .bus(b1));

    // Record every memory write and every PC-reset pulse of both instances.
    always @(negedge clock) begin
        if (b0.imem_we) begin
            wa0.push_back(int'(b0.imem_waddr));
            wd0.push_back(int'(b0.imem_wdata));
            mem0[b0.imem_waddr] = b0.imem_wdata;
        end
        if (b1.imem_we) begin
            wa1.push_back(int'(b1.imem_waddr));
            wd1.push_back(int'(b1.imem_wdata));
            mem1[b1.imem_waddr] = b1.imem_wdata;
        end
        if (b0.cpu_pc_reset) pulses0++;
        if (b1.cpu_pc_reset) pulses1++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_log();
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
        pulses0 = 0; pulses1 = 0;
        exp_w.delete();
    endtask

    task automatic send_byte(input int b);
        int t;
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) step();
        rx_valid = 1'b1;
        rx_data  = 8'(b);
        t = 0;
        while (b0.rx_ready !== 1'b1 && t < 40) begin
            step();
            t++;
        end
        chk("rx_ready_wait", 32'(t < 40), 32'd1);
        step();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic start_load();
        clear_log();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy",  32'(b0.busy),     32'd1);
        chk("start_hold",  32'(b0.cpu_hold), 32'd1);
        chk("start_ready", 32'(b0.rx_ready), 32'd1);
        chk("start_done",  32'(b0.done),     32'd0);
        chk("start_error", 32'(b0.error),    32'd0);
    endtask

    task automatic send_word(input int w);
        send_byte(w % 256);
        send_byte((w / 256) % 256);
        send_byte(w / 65536);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (b0.done !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        chk("done_wait",      32'(t < 20),          32'd1);
        chk("done_pc_reset",  32'(b0.cpu_pc_reset), 32'd1);
        chk("done_hold",      32'(b0.cpu_hold),     32'd0);
        chk("done_busy",      32'(b0.busy),         32'd0);
        chk("done1_done",     32'(b1.done),         32'd1);
        step();
        chk("pc_reset_drop",  32'(b0.cpu_pc_reset), 32'd0);
        chk("done_stays",     32'(b0.done),         32'd1);
        chk("pulses0",        32'(pulses0),         32'd1);
        chk("pulses1",        32'(pulses1),         32'd1);
    endtask

    // Compare the logged writes against (base + i) mod 4096 / exp_w[i].
    task automatic check_writes();
        chk("wcount0", 32'(wa0.size()), 32'(exp_w.size()));
        chk("wcount1", 32'(wa1.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wa0.size() && i < wa1.size(); i++) begin
            chk("waddr0", 32'(wa0[i]), 32'(i % 4096));
            chk("wdata0", 32'(wd0[i]), 32'(exp_w[i]));
            chk("waddr1", 32'(wa1[i]), 32'((4094 + i) % 4096));
            chk("wdata1", 32'(wd1[i]), 32'(exp_w[i]));
        end
    endtask

    // Full load of exp_w; optionally pulse start mid-load (must be ignored).
    task automatic load_list(input bit poke_start);
        int n;
        n = exp_w.size();
        send_byte(n % 256);
        send_byte(n / 256);
        for (int i = 0; i < n; i++) begin
            send_word(exp_w[i]);
            if (poke_start && i == 0) begin
                start = 1'b1;
                step();
                start = 1'b0;
                chk("busy_start_ignored", 32'(b0.busy), 32'd1);
            end
        end
        wait_done();
        check_writes();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(b0.rx_ready),     32'd0);
        chk({tag, "_we"},    32'(b0.imem_we),      32'd0);
        chk({tag, "_waddr"}, 32'(b0.imem_waddr),   32'd0);
        chk({tag, "_wdata"}, 32'(b0.imem_wdata),   32'd0);
        chk({tag, "_hold"},  32'(b0.cpu_hold),     32'd0);
        chk({tag, "_pcr"},   32'(b0.cpu_pc_reset), 32'd0);
        chk({tag, "_busy"},  32'(b0.busy),         32'd0);
        chk({tag, "_done"},  32'(b0.done),         32'd0);
        chk({tag, "_error"}, 32'(b0.error),        32'd0);
        chk({tag, "_hold1"}, 32'(b1.cpu_hold),     32'd0);
    endtask

    initial begin
        int n;
        int w1;
        // Reset state
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b1;
        step();
        chk_all_zero("idle");

        // Two-word directed load
        start_load();
        exp_w.push_back(32'h64);
        exp_w.push_back(32'h66);
        load_list(1'b0);

        // Zero-length header goes straight to DONE
        start_load();
        send_byte(0);
        send_byte(0);
        chk("zero_done",  32'(b0.done),         32'd1);
        chk("zero_pcr",   32'(b0.cpu_pc_reset), 32'd1);
        chk("zero_hold",  32'(b0.cpu_hold),     32'd0);
        step();
        chk("zero_pcr_drop", 32'(b0.cpu_pc_reset), 32'd0);
        chk("zero_writes",   32'(wa0.size()),      32'd0);
        chk("zero_pulses",   32'(pulses0),         32'd1);

        // Bad pad bits in the third byte
        start_load();
        send_byte(1);
        send_byte(0);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h08);
        chk("pad_error",  32'(b0.error),    32'd1);
        chk("pad_hold",   32'(b0.cpu_hold), 32'd1);
        chk("pad_ready",  32'(b0.rx_ready), 32'd0);
        chk("pad_busy",   32'(b0.busy),     32'd0);
        step();
        step();
        chk("pad_writes", 32'(wa0.size()),  32'd0);
        chk("pad_err_hold", 32'(b0.error),  32'd1);
        start_load();

        // Bad upper nibble in LEN_HI
        send_byte(5);
        send_byte(8'h10);
        chk("hdr_error", 32'(b0.error),    32'd1);
        chk("hdr_ready", 32'(b0.rx_ready), 32'd0);
        chk("hdr_hold",  32'(b0.cpu_hold), 32'd1);
        rx_valid = 1'b1;
        step();
        step();
        rx_valid = 1'b0;
        chk("hdr_ready_later", 32'(b0.rx_ready), 32'd0);

        // Three words: base-4094 instance wraps 4094, 4095, 0
        start_load();
        exp_w.push_back(32'h7ABCD);
        exp_w.push_back(32'h00001);
        exp_w.push_back(32'h40000);
        load_list(1'b0);

        // Randomized loads
        for (int k = 0; k < 6; k++) begin
            start_load();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) exp_w.push_back(int'($urandom_range(0, 19'h7FFFF)));
            load_list(k % 2 == 1);
        end

        // Reset in the middle of word 2
        start_load();
        w1 = int'($urandom_range(0, 19'h7FFFF));
        send_byte(3);
        send_byte(0);
        send_word(w1);
        send_byte($urandom_range(0, 255));
        chk("mid_busy", 32'(b0.busy), 32'd1);
        reset = 1'b0;
        step();
        chk_all_zero("midrst");
        chk("midrst_mem0", 32'(mem0[0]),    32'(w1));
        chk("midrst_mem1", 32'(mem1[4094]), 32'(w1));
        chk("midrst_wr",   32'(wa0.size()), 32'd1);
        reset = 1'b1;
        step();

        // Recovery after reset
        start_load();
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) exp_w.push_back(int'($urandom_range(0, 19'h7FFFF)));
        load_list(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
